// File: rtl/riscv_dbg_master_if.sv
// Debug-master bus bundle: host command/response channel,
// halt/resume controls and the core debug-port signals.
interface riscv_dbg_master_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 16
);
  logic              host_halt;
  logic              host_resume;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [XLEN-1:0]   cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;
  logic              halted;
  logic              bp_halted;
  logic              dbg_stall;
  logic              dbg_strb;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [XLEN-1:0]   dbg_dati;
  logic [XLEN-1:0]   dbg_dato;
  logic              dbg_ack;
  logic              dbg_bp;

  modport master (
    input  host_halt, host_resume,
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    input  rsp_ready,
    input  dbg_dato, dbg_ack, dbg_bp,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output halted, bp_halted,
    output dbg_stall, dbg_strb, dbg_we,
    output dbg_addr, dbg_dati
  );

  modport slave (
    output host_halt, host_resume,
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    output rsp_ready,
    output dbg_dato, dbg_ack, dbg_bp,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  halted, bp_halted,
    input  dbg_stall, dbg_strb, dbg_we,
    input  dbg_addr, dbg_dati
  );
endinterface

// File: rtl/riscv_dbg_master.sv
// CPU debug-port initiator: single-access strobe FSM plus stall control.
// Define DBG_TIMEOUT_EN to abort strobes that see no ack within TIMEOUT.
module riscv_dbg_master #(
  parameter int         XLEN          = 32,
  parameter int         ADDR_W        = 16,
  parameter logic [3:0] BANK_INTERNAL = 4'h0,
  parameter int         TIMEOUT       = 255
) (
  input  logic               clk,
  input  logic               rstn,
  riscv_dbg_master_if.master bus
);
  localparam int BANK_W = ADDR_W - 12;

  typedef enum logic [1:0] {
    IDLE,
    STRB,
    RSP
  } state_e;

  state_e state_q, state_d;

  logic              live_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;
  logic              stall_q;
  logic              bp_q;
  logic              pend_q;

  logic cmd_fire;
  logic reject;
  logic bp_ev;
  logic halt_ev;
  logic resume_ev;
  logic to_hit;

`ifdef DBG_TIMEOUT_EN
  logic [7:0] cnt_q;

  assign to_hit = (state_q == STRB) && !bus.dbg_ack
               && (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (state_q == STRB) begin
      cnt_q <= cnt_q + 8'd1;
    end else begin
      cnt_q <= '0;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // live_q keeps cmd_ready low while reset is asserted
  assign cmd_fire = bus.cmd_valid && live_q
                 && (state_q == IDLE);
  assign reject = !stall_q
               && (bus.cmd_addr[ADDR_W-1:12]
                   != BANK_W'(BANK_INTERNAL));

  assign bp_ev     = bus.dbg_bp && !stall_q;
  assign halt_ev   = bus.host_halt || bp_ev;
  assign resume_ev = (pend_q || bus.host_resume) && !halt_ev;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cmd_fire) state_d = reject ? RSP : STRB;
      STRB: if (bus.dbg_ack || to_hit) state_d = RSP;
      RSP:  if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (cmd_fire) begin
        we_q    <= bus.cmd_we;
        addr_q  <= bus.cmd_addr;
        wdata_q <= bus.cmd_wdata;
        if (reject) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
      if (state_q == STRB) begin
        if (bus.dbg_ack) begin
          rdata_q <= we_q ? '0 : bus.dbg_dato;
          err_q   <= 1'b0;
        end else if (to_hit) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  // resume waits for an idle cycle with no new access starting
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= 1'b0;
      bp_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else if (halt_ev) begin
      stall_q <= 1'b1;
      pend_q  <= 1'b0;
      if (bp_ev) bp_q <= 1'b1;
    end else if (resume_ev) begin
      if (state_q == IDLE && !cmd_fire) begin
        stall_q <= 1'b0;
        bp_q    <= 1'b0;
        pend_q  <= 1'b0;
      end else begin
        pend_q  <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready = live_q && (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RSP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.halted    = stall_q;
  assign bus.bp_halted = bp_q;
  assign bus.dbg_stall = stall_q;
  assign bus.dbg_strb  = (state_q == STRB);
  assign bus.dbg_we    = we_q;
  assign bus.dbg_addr  = addr_q;
  assign bus.dbg_dati  = wdata_q;
endmodule

// File: tb/tb_riscv_dbg_master.sv
// Bench for riscv_dbg_master: directed and randomized accesses
// and halt/resume events checked against a transaction-level model.
module tb_riscv_dbg_master;
`ifdef DBG_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic clk = 1'b0;
  logic rstn;
  int   vecs = 0;
  int   errs = 0;
  int   cyc  = 0;
  int   last_fall = -1;
  bit   m_halt;
  bit   m_bp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  riscv_dbg_master_if #(.XLEN(32), .ADDR_W(16)) b ();

  riscv_dbg_master #(.TIMEOUT(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h, expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {b.cmd_ready, b.rsp_valid, b.rsp_rdata,
            b.rsp_err, b.halted, b.bp_halted,
            b.dbg_stall, b.dbg_strb, b.dbg_we,
            b.dbg_addr, b.dbg_dati};
  endfunction

  task automatic chk_stall(input string tag);
    check(tag, {b.halted, b.dbg_stall, b.bp_halted},
          {m_halt, m_halt, m_bp});
  endtask

  // halt/resume/bp in idle; a second cycle shows no late effect
  task automatic pulse(input bit h, input bit r, input bit bp);
    b.host_halt   = h;
    b.host_resume = r;
    b.dbg_bp      = bp;
    tick();
    b.host_halt   = 1'b0;
    b.host_resume = 1'b0;
    b.dbg_bp      = 1'b0;
    if (h || (bp && !m_halt)) begin
      if (bp && !m_halt) m_bp = 1'b1;
      m_halt = 1'b1;
    end else if (r) begin
      m_halt = 1'b0;
      m_bp   = 1'b0;
    end
    chk_stall("stall_next");
    tick();
    chk_stall("stall_settled");
  endtask

  task automatic access(input logic        we,
                        input logic [15:0] addr,
                        input logic [31:0] wd,
                        input logic [31:0] dato,
                        input int          ack_lat,
                        input int          rdy_lat,
                        input bit          res_mid);
    logic        rej;
    logic [31:0] exp_rd;
    rej    = (addr[15:12] != 4'h0) && !m_halt;
    exp_rd = (rej || we) ? 32'h0 : dato;
    b.cmd_valid = 1'b1;
    b.cmd_we    = we;
    b.cmd_addr  = addr;
    b.cmd_wdata = wd;
    check("cmd_ready", b.cmd_ready, 1);
    tick();
    b.cmd_valid = 1'b0;
    b.cmd_we    = ~we;
    b.cmd_addr  = 16'($urandom);
    b.cmd_wdata = $urandom;
    if (!rej) begin
      check("strb_rise",
            {b.dbg_strb, b.dbg_we, b.dbg_addr, b.dbg_dati},
            {1'b1, we, addr, wd});
      if (last_fall >= 0)
        check("strb_gap", 1'(cyc - last_fall >= 2), 1);
      if (res_mid) begin
        b.host_resume = 1'b1;
        check("res_strb", b.halted, 1);
      end
      for (int i = 0; i < ack_lat; i++) begin
        tick();
        b.host_resume = 1'b0;
        check("strb_hold",
              {b.dbg_strb, b.dbg_we, b.dbg_addr, b.dbg_dati},
              {1'b1, we, addr, wd});
        if (res_mid) check("res_strb", b.halted, 1);
      end
      b.dbg_ack  = 1'b1;
      b.dbg_dato = dato;
      tick();
      b.dbg_ack     = 1'b0;
      b.host_resume = 1'b0;
      b.dbg_dato    = $urandom;
      last_fall     = cyc;
    end else begin
      check("rej_nostrb", b.dbg_strb, 0);
    end
    check("rsp",
          {b.dbg_strb, b.rsp_valid, b.rsp_err, b.rsp_rdata},
          {1'b0, 1'b1, rej, exp_rd});
    for (int i = 0; i < rdy_lat; i++) begin
      tick();
      check("rsp_hold",
            {b.dbg_strb, b.rsp_valid, b.rsp_err, b.rsp_rdata},
            {1'b0, 1'b1, rej, exp_rd});
      if (res_mid) check("res_rsp", b.halted, 1);
    end
    b.rsp_ready = 1'b1;
    tick();
    b.rsp_ready = 1'b0;
    check("rsp_done", {b.rsp_valid, b.cmd_ready}, 2'b01);
    if (res_mid) begin
      check("res_idle_first", b.halted, 1);
      tick();
      m_halt = 1'b0;
      m_bp   = 1'b0;
      chk_stall("res_applied");
    end
  endtask

  initial begin
    int          n;
    logic [15:0] ra;
    rstn          = 1'b0;
    b.host_halt   = 1'b0;
    b.host_resume = 1'b0;
    b.cmd_valid   = 1'b0;
    b.cmd_we      = 1'b0;
    b.cmd_addr    = '0;
    b.cmd_wdata   = '0;
    b.rsp_ready   = 1'b0;
    b.dbg_dato    = '0;
    b.dbg_ack     = 1'b0;
    b.dbg_bp      = 1'b0;
    m_halt        = 1'b0;
    m_bp          = 1'b0;
    n             = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", all_outs(), '0);
    rstn = 1'b1;
    tick();
    tick();
    check("ready_after_reset", b.cmd_ready, 1);
    chk_stall("running_after_reset");

    access(1'b1, 16'h0000, 32'h1, $urandom, 1, 0, 1'b0);
    access(1'b0, 16'h0004, 32'h0, 32'h12345678, 0, 0, 1'b0);
    access(1'b0, 16'h1000, 32'h0, $urandom, 0, 1, 1'b0);

    pulse(1'b1, 1'b0, 1'b0);
    access(1'b0, 16'h1000, 32'h0, 32'hDEADBEEF, 2, 0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);

    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);

    pulse(1'b1, 1'b0, 1'b0);
    access(1'b0, 16'h2010, 32'h0, $urandom, 3, 2, 1'b1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0: pulse(1'b1, 1'b0, 1'b0);
        1: pulse(1'b0, 1'b1, 1'b0);
        2: pulse(1'b0, 1'b0, 1'b1);
        3: pulse(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        default: ;
      endcase
      ra = 16'($urandom);
      if ($urandom_range(0, 1) == 1) ra[15:12] = 4'h0;
      access(1'($urandom_range(0, 1)), ra, $urandom, $urandom,
             $urandom_range(0, 4), $urandom_range(0, 3),
             m_halt && ($urandom_range(0, 3) == 0));
    end

`ifdef DBG_TIMEOUT_EN
    b.cmd_valid = 1'b1;
    b.cmd_we    = 1'b0;
    b.cmd_addr  = 16'h0010;
    tick();
    b.cmd_valid = 1'b0;
    n = 0;
    while (b.dbg_strb && n < 3 * TO) begin
      n++;
      tick();
    end
    check("to_len", n, TO);
    check("to_rsp", {b.rsp_valid, b.rsp_err, b.rsp_rdata},
          {1'b1, 1'b1, 32'h0});
    b.dbg_ack  = 1'b1;
    b.dbg_dato = 32'hFFFFFFFF;
    tick();
    b.dbg_ack = 1'b0;
    check("late_ack_rsp", {b.rsp_valid, b.rsp_err, b.rsp_rdata},
          {1'b1, 1'b1, 32'h0});
    b.rsp_ready = 1'b1;
    tick();
    b.rsp_ready = 1'b0;
    b.dbg_ack   = 1'b1;
    tick();
    b.dbg_ack = 1'b0;
    check("late_ack_idle", {b.dbg_strb, b.rsp_valid}, 2'b00);
    last_fall = -1;
`endif

    pulse(1'b1, 1'b0, 1'b0);
    b.cmd_valid = 1'b1;
    b.cmd_we    = 1'b1;
    b.cmd_addr  = 16'h0ABC;
    b.cmd_wdata = 32'hCAFEF00D;
    tick();
    b.cmd_valid = 1'b0;
    check("pre_reset_strb", {b.dbg_strb, b.dbg_addr}, {1'b1, 16'h0ABC});
    #2;
    rstn = 1'b0;
    #1;
    check("reset_mid", all_outs(), '0);
    @(negedge clk);
    rstn = 1'b1;
    m_halt = 1'b0;
    m_bp   = 1'b0;
    last_fall = -1;
    tick();
    tick();
    check("post_reset", {b.rsp_valid, b.cmd_ready, b.dbg_strb},
          3'b010);
    chk_stall("post_reset_stall");
    access(1'b0, 16'h0008, 32'h0, 32'h0BADCAFE, 1, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule
